// File: rtl/absorb_load_datapath_pkg.sv
// absorb_load_datapath_pkg: shared constants, load FSM states and rate helpers; define SHA3_DOMAIN_EN to add SHA3-256 (0x06 domain)
package absorb_load_datapath_pkg;
    localparam int LANE_W = 64;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;
    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;
    localparam logic [1:0] SHA3_256_MODE_VEC = 2'b10;
    localparam logic [7:0] SHAKE_DOMAIN_BYTE = 8'h1F;
    localparam logic [7:0] PAD_FINAL_BYTE = 8'h80;
    localparam logic [7:0] SHA3_DOMAIN_BYTE = 8'h06;
    typedef enum logic [1:0] {IDLE, FILL, PAD, HOLD} load_state_t;
    function automatic logic [4:0] rate_words(input logic [1:0] mode);
`ifdef SHA3_DOMAIN_EN
        return (mode == SHAKE256_MODE_VEC || mode == SHA3_256_MODE_VEC) ? 5'd17 : 5'd21;
`else
        return (mode == SHAKE256_MODE_VEC) ? 5'd17 : 5'd21;
`endif
    endfunction
    function automatic logic [7:0] domain_byte(input logic [1:0] mode);
`ifdef SHA3_DOMAIN_EN
        return (mode == SHA3_256_MODE_VEC) ? SHA3_DOMAIN_BYTE : SHAKE_DOMAIN_BYTE;
`else
        return (mode == SHA3_256_MODE_VEC) ? SHAKE_DOMAIN_BYTE : SHAKE_DOMAIN_BYTE;
`endif
    endfunction
    function automatic logic [LANE_W-1:0] byte_swap(input logic [LANE_W-1:0] x);
        logic [LANE_W-1:0] y;
        for (int j = 0; j < LANE_W / 8; j++) y[8*j +: 8] = x[LANE_W-8-8*j +: 8];
        return y;
    endfunction
endpackage

// File: rtl/absorb_load_datapath_sipo_buffer.sv
// sipo_buffer: word-indexed serial-in block buffer with an OR-write port for padding and synchronous clear
// ports: clk, rst; i_clr clears all words; i_wr_* overwrites word i_wr_idx; i_or_* ORs into word i_or_idx; o_words is the whole buffer
module sipo_buffer #(
    parameter int W = 64,
    parameter int MAX_WORDS = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_wr_en,
    input  logic [4:0]   i_wr_idx,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_or_en,
    input  logic [4:0]   i_or_idx,
    input  logic [W-1:0] i_or_data,
    output logic [W-1:0] o_words [MAX_WORDS]
);
    // write and OR may hit the same word in one cycle; both land, which yields the merged 0x9F pad byte
    always_ff @(posedge clk)
        for (int i = 0; i < MAX_WORDS; i++)
            o_words[i] <= (rst || i_clr) ? '0 :
                ((i_wr_en && i_wr_idx == 5'(i)) ? i_wr_data : o_words[i]) |
                ((i_or_en && i_or_idx == 5'(i)) ? i_or_data : '0);
endmodule

// File: rtl/absorb_load_datapath.sv
// absorb_load_datapath: assembles message words into padded SHAKE rate blocks for the permute stage; SHA3_DOMAIN_EN adds SHA3-256
// ports: data_* message stream in (valid/ready, last + byte count); operation_mode_in/output_size_in sampled on first word;
//        rate_output/block_valid/block_ready/block_last block handshake out; operation_mode_out/output_size_out latched per message
module absorb_load_datapath
    import absorb_load_datapath_pkg::*;
#(
    parameter int W = LANE_W,
    parameter int MAX_WORDS = RATE_SHAKE128 / LANE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    input  logic                     data_last,
    input  logic [3:0]               data_last_bytes,
    input  logic [1:0]               operation_mode_in,
    input  logic [31:0]              output_size_in,
    output logic [RATE_SHAKE128-1:0] rate_output,
    output logic                     block_valid,
    input  logic                     block_ready,
    output logic                     block_last,
    output logic [1:0]               operation_mode_out,
    output logic [31:0]              output_size_out
);
    load_state_t r_state, w_next;
    logic [4:0] r_k, w_k_next;
    logic r_last, w_last_next, r_extra, w_extra_next;
    logic [1:0] r_mode;
    logic [31:0] r_size;
    logic [W-1:0] w_words [MAX_WORDS];
    logic w_accept, w_wr_en, w_or_en, w_clr, w_full;
    logic [4:0] w_wr_idx, w_slot, w_nw, w_onw;
    logic [W-1:0] w_wr_data, w_masked;
    logic [1:0] w_mode;
    logic [7:0] w_dom;
    logic [3:0] w_n;
    assign data_ready = !rst && (r_state == IDLE || r_state == FILL);
    assign block_valid = !rst && r_state == HOLD;
    assign block_last = !rst && r_last;
    assign operation_mode_out = r_mode;
    assign output_size_out = r_size;
    assign w_accept = data_valid && data_ready;
    // the first word of a message is steered by the live mode input, later words by the latched one
    assign w_mode = (r_state == IDLE) ? operation_mode_in : r_mode;
    assign w_nw = rate_words(w_mode);
    assign w_dom = domain_byte(w_mode);
    assign w_slot = (r_state == IDLE) ? 5'd0 : r_k;
    assign w_n = !data_last ? 4'(W / 8) : (data_last_bytes > 4'(W / 8)) ? 4'(W / 8) : data_last_bytes;
    assign w_full = w_n == 4'(W / 8);
    assign w_onw = rate_words(r_mode);
    always_comb begin
        w_masked = '0;
        for (int j = 0; j < W / 8; j++)
            w_masked[8*j +: 8] = (4'(j) < w_n) ? data_in[8*j +: 8] : (4'(j) == w_n) ? w_dom : 8'h00;
    end
    always_comb begin
        rate_output = '0;
        for (int k = 0; k < MAX_WORDS; k++)
            if (5'(k) < w_onw) rate_output[int'(w_onw)*W-1-W*k -: W] = byte_swap(w_words[k]);
    end
    always_comb begin
        w_next = r_state;
        w_k_next = r_k;
        w_last_next = r_last;
        w_extra_next = r_extra;
        w_wr_en = 1'b0;
        w_wr_idx = w_slot;
        w_wr_data = w_masked;
        w_or_en = 1'b0;
        w_clr = 1'b0;
        case (r_state)
            IDLE, FILL: if (w_accept) begin
                w_wr_en = 1'b1;
                w_k_next = w_slot + 5'd1;
                if (data_last && !w_full) begin
                    w_or_en = 1'b1;
                    w_next = HOLD;
                    w_last_next = 1'b1;
                end else if (data_last && w_slot != w_nw - 5'd1) begin
                    w_next = PAD;
                end else if (w_slot == w_nw - 5'd1) begin
                    // a full final word that fills the block needs a whole extra padding block
                    w_next = HOLD;
                    w_last_next = 1'b0;
                    w_extra_next = data_last;
                end else begin
                    w_next = FILL;
                end
            end
            PAD: begin
                w_wr_en = 1'b1;
                w_wr_idx = r_k;
                w_wr_data = W'(w_dom);
                w_or_en = 1'b1;
                w_next = HOLD;
                w_last_next = 1'b1;
                w_extra_next = 1'b0;
            end
            default: if (block_ready) begin
                w_clr = 1'b1;
                w_k_next = 5'd0;
                w_last_next = 1'b0;
                w_extra_next = 1'b0;
                w_next = r_extra ? PAD : r_last ? IDLE : FILL;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
        r_k <= rst ? 5'd0 : w_k_next;
        r_last <= rst ? 1'b0 : w_last_next;
        r_extra <= rst ? 1'b0 : w_extra_next;
        r_mode <= rst ? 2'd0 : (w_accept && r_state == IDLE) ? operation_mode_in : r_mode;
        r_size <= rst ? 32'd0 : (w_accept && r_state == IDLE) ? output_size_in : r_size;
    end
    sipo_buffer #(.W(W), .MAX_WORDS(MAX_WORDS)) u_buf (
        .clk(clk),
        .rst(rst),
        .i_clr(w_clr),
        .i_wr_en(w_wr_en),
        .i_wr_idx(w_wr_idx),
        .i_wr_data(w_wr_data),
        .i_or_en(w_or_en),
        .i_or_idx(w_nw - 5'd1),
        .i_or_data(W'(PAD_FINAL_BYTE) << (W - 8)),
        .o_words(w_words)
    );
endmodule
